// File: rtl/mtl1_bus_pkg.sv
// Shared MTL-1 bus definitions: flash window bounds, SPI opcodes, the flash
// reader state encoding and its debug view.
package mtl1_bus_pkg;

    localparam logic [15:0] FLASH_START  = 16'h3000;
    localparam logic [15:0] FLASH_END    = 16'h7FFF;
    localparam logic [7:0]  SPI_CMD_READ = 8'h03;

    // Cumulative SCLK rising-edge counts at which each phase completes.
    localparam logic [5:0]  CMD_BITS     = 6'd8;
    localparam logic [5:0]  ADDR_BITS    = 6'd32;
    localparam logic [5:0]  TOTAL_BITS   = 6'd40;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE,
        HOLD
    } state_t;

    typedef struct packed {
        state_t      state;
        logic [5:0]  bit_cnt;
        logic [23:0] flash_addr;
    } dbg_t;

    // CPU address to flash byte address; the sum wraps modulo 2^24.
    function automatic logic [23:0] flash_offset(input logic [15:0] cpu_addr,
                                                 input logic [15:0] win_start,
                                                 input logic [23:0] base);
        logic [15:0] delta;
        delta = cpu_addr - win_start;
        return base + {8'h00, delta};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: toggles SCLK every CLK_DIV cycles while enabled and flags
// the edge on which SCLK is about to rise or fall.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;
    logic       tick;

    assign tick = en & (div_cnt == DIV_LAST);
    assign rise = tick & ~sclk;
    assign fall = tick & sclk;

    // Dropping the enable parks SCLK low, ready for the next mode-0 frame.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div_cnt <= 8'd0;
            sclk    <= 1'b0;
        end else if (tick) begin
            div_cnt <= 8'd0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// 6809 flash-window responder: turns reads in the window into SPI READ (0x03)
// transactions and holds MRDY low until the byte returns.
// Optional single-entry read cache: define SPI_READ_CACHE_EN.
module spi_flash_reader
    import mtl1_bus_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 2,
    parameter logic [15:0] WINDOW_START = FLASH_START,
    parameter logic [23:0] FLASH_BASE   = 24'h000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_spi_ce,
    input  logic        i_FT_CS,
    input  logic        i_rw,
    input  logic [15:0] i_address,
    output logic [7:0]  o_data,
    output logic        o_data_valid,
    output logic        o_mrdy,
    output logic        o_busy,
    output logic        o_spi_oe,
    output logic        o_spi_cs_n,
    output logic        o_spi_sclk,
    output logic        o_spi_mosi,
    input  logic        i_spi_miso,
    output dbg_t        o_dbg
);

    state_t      state;
    logic [31:0] shift_reg;
    logic [7:0]  rx_byte;
    logic [5:0]  bit_cnt;
    logic [23:0] flash_addr;
    logic        run;

    logic        req;
    logic        hit;
    logic [7:0]  hit_byte;
    logic        in_xfer;
    logic        done_now;
    logic        spi_rise;
    logic        spi_fall;
    logic [23:0] next_addr;

    assign req       = i_spi_ce & i_rw & i_FT_CS;
    assign next_addr = flash_offset(i_address, WINDOW_START, FLASH_BASE);
    assign in_xfer   = state inside {CMD, ADDR, DATA};
    assign done_now  = (state == DATA) & i_FT_CS & ~run & (bit_cnt == TOTAL_BITS);

    // Combinational so the 6809 is stretched in the very cycle it presents the address.
    assign o_mrdy = ~(((state == IDLE) & req & ~hit & ~i_reset) | in_xfer);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk   (i_clk),
        .reset (i_reset),
        .en    (run & i_FT_CS),
        .sclk  (o_spi_sclk),
        .rise  (spi_rise),
        .fall  (spi_fall)
    );

`ifdef SPI_READ_CACHE_EN
    logic        cache_valid;
    logic [23:0] cache_addr;
    logic [7:0]  cache_byte;

    assign hit      = cache_valid & (next_addr == cache_addr);
    assign hit_byte = cache_byte;

    // Any FT2232 ownership may have rewritten the flash, so the entry is dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_FT_CS) begin
            cache_valid <= 1'b0;
        end else if (done_now) begin
            cache_valid <= 1'b1;
            cache_addr  <= flash_addr;
            cache_byte  <= rx_byte;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_byte = 8'hFF;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            o_data       <= 8'hFF;
            o_data_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_spi_oe     <= 1'b0;
            o_spi_cs_n   <= 1'b1;
            o_spi_mosi   <= 1'b0;
            shift_reg    <= 32'd0;
            rx_byte      <= 8'd0;
            bit_cnt      <= 6'd0;
            flash_addr   <= 24'd0;
            run          <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        o_data       <= hit_byte;
                        o_data_valid <= 1'b1;
                        state        <= HOLD;
                    end else if (req) begin
                        flash_addr <= next_addr;
                        shift_reg  <= {SPI_CMD_READ, next_addr};
                        o_spi_mosi <= SPI_CMD_READ[7];
                        o_spi_oe   <= 1'b1;
                        o_spi_cs_n <= 1'b0;
                        o_busy     <= 1'b1;
                        bit_cnt    <= 6'd0;
                        run        <= 1'b0;
                        state      <= CMD;
                    end
                end
                CMD, ADDR, DATA: begin
                    if (!i_FT_CS) begin
                        o_spi_oe     <= 1'b0;
                        o_spi_cs_n   <= 1'b1;
                        o_spi_mosi   <= 1'b0;
                        o_data       <= 8'hFF;
                        o_data_valid <= 1'b1;
                        o_busy       <= 1'b0;
                        run          <= 1'b0;
                        state        <= HOLD;
                    end else begin
                        // One idle cycle of CS setup before SCLK starts.
                        if (state == CMD && bit_cnt == 6'd0 && !run) begin
                            run <= 1'b1;
                        end
                        if (spi_rise) begin
                            bit_cnt <= bit_cnt + 6'd1;
                            if (state == DATA) begin
                                rx_byte <= {rx_byte[6:0], i_spi_miso};
                            end
                        end
                        if (spi_fall) begin
                            if (bit_cnt == TOTAL_BITS) begin
                                run <= 1'b0;
                            end else begin
                                shift_reg  <= {shift_reg[30:0], 1'b0};
                                o_spi_mosi <= shift_reg[30];
                            end
                            if (state == CMD && bit_cnt == CMD_BITS) begin
                                state <= ADDR;
                            end
                            if (state == ADDR && bit_cnt == ADDR_BITS) begin
                                state <= DATA;
                            end
                        end
                        if (done_now) begin
                            o_spi_cs_n   <= 1'b1;
                            o_data       <= rx_byte;
                            o_data_valid <= 1'b1;
                            o_busy       <= 1'b0;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    o_spi_oe <= 1'b0;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (!i_spi_ce) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_dbg            = '0;
        o_dbg.state      = state;
        o_dbg.bit_cnt    = bit_cnt;
        o_dbg.flash_addr = flash_addr;
    end

endmodule
